// File: rtl/disp_bcd_formatter.sv
// MMIO front end for the 7-segment driver: forwards raw hex writes and converts
// decimal writes to packed BCD with a sequential double-dabble engine.
module disp_bcd_formatter #(
    parameter logic [11:0] ADDR_HEX    = 12'h000,
    parameter logic [11:0] ADDR_DEC    = 12'h004,
    parameter logic [31:0] ERR_PATTERN = 32'hEEEEEEEE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic        out_wen,
    output logic [31:0] out_wdata,
    output logic        busy
);

    localparam logic [31:0] DEC_LIMIT = 32'd100_000_000;
    localparam logic [4:0]  LAST_ITER = 5'd26;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t      state;
    logic [26:0] bin_q;
    logic [31:0] bcd_q;
    logic [4:0]  cnt_q;

    logic        hex_wr;
    logic        dec_wr;
    logic [31:0] bcd_adj;
    logic [31:0] bcd_nxt;
    logic [26:0] bin_nxt;

    assign hex_wr = wen && (addr == ADDR_HEX);
    assign dec_wr = wen && (addr == ADDR_DEC);

    // Each nibble is corrected on its own, so no carry can cross a digit boundary.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        bcd_adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_nxt = {bcd_adj[30:0], bin_q[26]};
        bin_nxt = {bin_q[25:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        // NOTE: state is assigned with <= so every register samples pre-edge values.
        if (!rst) begin
            state     <= IDLE;
            out_wen   <= 1'b0;
            out_wdata <= '0;
            busy      <= 1'b0;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
        end else begin
            out_wen <= 1'b0;
            // A new accepted write always pre-empts a conversion in flight.
            if (hex_wr) begin
                state     <= IDLE;
                busy      <= 1'b0;
                out_wen   <= 1'b1;
                out_wdata <= wdata;
            end else if (dec_wr && (wdata >= DEC_LIMIT)) begin
                state     <= IDLE;
                busy      <= 1'b0;
                out_wen   <= 1'b1;
                out_wdata <= ERR_PATTERN;
            end else if (dec_wr) begin
                state <= CONV;
                busy  <= 1'b1;
                bin_q <= wdata[26:0];
                bcd_q <= '0;
                cnt_q <= '0;
            end else if (state == CONV) begin
                bin_q <= bin_nxt;
                bcd_q <= bcd_nxt;
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_wen   <= 1'b1;
                    out_wdata <= bcd_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_disp_bcd_formatter.sv
// Scoreboard bench for disp_bcd_formatter: stimulus queues expected strobes,
// a negedge monitor pops and compares data, latency and busy on every out_wen.
module tb_disp_bcd_formatter;

    localparam logic [11:0] A_HEX = 12'h000;
    localparam logic [11:0] A_DEC = 12'h004;
    localparam logic [11:0] A_BAD = 12'h008;
    localparam int          CONV_LAT = 27;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [11:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic        out_wen;
    logic [31:0] out_wdata;
    logic        busy;

    exp_t        sb[$];
    int          cyc;
    int          checks;
    int          errors;
    logic [31:0] held;

    disp_bcd_formatter dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wen       (wen),
        .wdata     (wdata),
        .out_wen   (out_wen),
        .out_wdata (out_wdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expectation; idle cycles must hold data.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (out_wen === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got data 0x%08h expected no strobe (cycle %0d)", out_wdata, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("strobe_data", out_wdata, e.data);
                    check("strobe_cycle", cyc, e.due);
                    check("strobe_busy", {31'd0, busy}, 32'd0);
                    held = e.data;
                end
            end else begin
                check("hold_data", out_wdata, held);
            end
        end
    end

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d,
                             input bit expect_out, input logic [31:0] exp_data, input int lat);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        if (expect_out) sb.push_back('{data: exp_data, due: cyc + 1 + lat});
        @(negedge clk);
        wen   = 1'b0;
        addr  = 12'h0ff;
        wdata = 32'h0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d strobes pending expected 0 after timeout", name, sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Issues a DEC write and measures how many sampled cycles busy stays high.
    task automatic dec_run(input logic [31:0] value, input logic [31:0] bcd);
        int n;
        bus_write(A_DEC, value, 1'b1, bcd, CONV_LAT);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, CONV_LAT);
        drain("dec_drain");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        held   = 32'h0;
        rst    = 1'b0;
        wen    = 1'b0;
        addr   = 12'h0;
        wdata  = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_out_wen", {31'd0, out_wen}, 32'd0);
        check("reset_out_wdata", out_wdata, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        bus_write(A_HEX, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 0);
        check("hex_busy", {31'd0, busy}, 32'd0);
        drain("hex_drain");

        dec_run(32'h00BC614E, 32'h12345678);
        dec_run(32'd0,        32'h00000000);
        dec_run(32'd99999999, 32'h99999999);
        dec_run(32'd1000,     32'h00001000);

        bus_write(A_DEC, 32'd100000000, 1'b1, 32'hEEEEEEEE, 0);
        check("err_busy", {31'd0, busy}, 32'd0);
        drain("err_drain");
        bus_write(A_DEC, 32'hFFFFFFFF, 1'b1, 32'hEEEEEEEE, 0);
        drain("err_max_drain");

        // Restart: only the second value may ever appear.
        bus_write(A_DEC, 32'd5, 1'b0, 32'h0, 0);
        repeat (8) @(negedge clk);
        bus_write(A_DEC, 32'd42, 1'b1, 32'h00000042, CONV_LAT);
        drain("restart_drain");

        // Reset mid-conversion aborts the value and clears the output word.
        bus_write(A_DEC, 32'd77, 1'b0, 32'h0, 0);
        repeat (9) @(negedge clk);
        rst  = 1'b0;
        held = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_out_wdata", out_wdata, 32'h0);

        // HEX write cancels the conversion; its word is the only strobe.
        bus_write(A_DEC, 32'd77, 1'b0, 32'h0, 0);
        repeat (4) @(negedge clk);
        bus_write(A_HEX, 32'h00000001, 1'b1, 32'h00000001, 0);
        check("cancel_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        drain("cancel_drain");

        bus_write(A_BAD, 32'h12345678, 1'b0, 32'h0, 0);
        check("bad_addr_busy", {31'd0, busy}, 32'd0);
        repeat (35) @(negedge clk);
        check("bad_addr_out_wdata", out_wdata, 32'h00000001);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/disp_bcd_formatter.md
Name: disp_bcd_formatter

Overview:
- Upstream stage of the 7-segment display driver; it sits between the CPU MMIO write bus and the driver's addr/wen/wdata inputs.
- Decodes two display addresses:
  - HEX address: the raw 32-bit write is forwarded unchanged.
  - DEC address: the 27-bit binary value is converted to 8 packed BCD digits by a sequential double-dabble engine, then the BCD word is forwarded.
- Gives the board a decimal readout with no software conversion.

Parameters:
- ADDR_HEX, 12'h000, bus address for raw hex pass-through writes
- ADDR_DEC, 12'h004, bus address for binary-to-decimal writes
- ERR_PATTERN, 32'hEEEEEEEE, word forwarded when the decimal value exceeds 8 digits

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- addr  input  12  CPU MMIO write address
- wen  input  1  CPU write strobe, one cycle per write
- wdata  input  32  CPU write data
- out_wen  output  1  one-cycle write strobe to the display driver
- out_wdata  output  32  data to the display driver; held stable between strobes
- busy  output  1  high while a conversion is in flight

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, out_wen=0, out_wdata=0, busy=0, iteration counter=0. Reset mid-conversion aborts it; no out_wen is produced for the aborted value.
- FSM states:
  - IDLE: no conversion in flight.
  - CONV: one double-dabble iteration per clock, 27 iterations total.
- Accepted write: wen=1 and addr matches ADDR_HEX or ADDR_DEC. Any other address is ignored with no state change.
- HEX write at edge E0:
  - out_wdata=wdata and out_wen=1 at E0; the strobe is visible the cycle after E0 (1-cycle latency).
  - Any in-flight conversion is cancelled (state->IDLE, busy=0). Latest write wins.
- DEC write, wdata[31:0] >= 100000000:
  - out_wdata=ERR_PATTERN and out_wen=1 at E0 (1-cycle latency).
  - Any in-flight conversion is cancelled.
- DEC write, value < 100000000:
  - At E0: load binary shift reg = wdata[26:0], BCD reg = 0, counter=0, state->CONV, busy=1.
  - Each CONV edge: every BCD nibble >= 5 gets +3, then {bcd,bin} is shifted left by 1 and the counter increments.
  - At the edge completing iteration 27 (edge E27): out_wdata = final BCD word, out_wen=1, state->IDLE, busy=0.
  - The strobe is visible 27 cycles after acceptance.
- DEC write accepted while in CONV: restart with the new value, counter reset to 0. The old result is never emitted.
- out_wen is high for exactly one cycle per completed or forwarded write. It is deasserted on every other edge.
- out_wdata changes only on edges where out_wen is set.
- busy is low in IDLE, including the cycle in which out_wen is high after a conversion.
- Width rules:
  - BCD reg is 32 bits = 8 nibbles.
  - Add-3 is per nibble, 4 bits, with no carry between nibbles.
  - Inputs < 10^8 cannot overflow 8 digits.

Test Plan:
- Reset low for 3 cycles, then high -> out_wen=0, out_wdata=0, busy=0.
- HEX write 0xDEADBEEF at ADDR_HEX -> next cycle out_wen=1 for 1 cycle, out_wdata=0xDEADBEEF; busy stays 0.
- DEC writes, one per run:
  - 12345678 (0x00BC614E) -> busy=1 for 27 cycles, then out_wen 1 cycle with out_wdata=0x12345678.
  - 0 -> 0x00000000.
  - 99999999 -> 0x99999999.
- DEC write 100000000 -> next cycle out_wen=1, out_wdata=0xEEEEEEEE.
- DEC write 5, then DEC write 42 ten cycles later -> exactly one out_wen, 27 cycles after the second write, with out_wdata=0x00000042.
- DEC write 77 with reset asserted at iteration 10 -> no out_wen ever, out_wdata=0.
- DEC write 77, then HEX write 0x1 at iteration 5 -> single strobe with 0x00000001, busy=0.
- Write to addr 12'h008 -> no output activity.
